// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM encoding and default widths for the two-client memory port arbiter.
package mem_port_arbiter_pkg;
  localparam int CTAG_W = 5;
  localparam int DATA_BEATS = 4;
  localparam int ID_W = 1;
  typedef enum logic [1:0] {IDLE, CMD, WDATA} state_t;
endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; on a tie the client not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       win
);
  always_comb win = &req ? ~last : req[1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream memory port between two clients, locking the grant
// for the whole command plus write burst and routing read responses back by tag.
module mem_port_arbiter #(
  parameter int ADDR_W = 26,
  parameter int DATA_BEATS = mem_port_arbiter_pkg::DATA_BEATS,
  parameter int CTAG_W = mem_port_arbiter_pkg::CTAG_W
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic                                       c0_cmd_valid,
  output logic                                       c0_cmd_ready,
  input  logic [ADDR_W-1:0]                          c0_cmd_addr,
  input  logic [CTAG_W-1:0]                          c0_cmd_tag,
  input  logic                                       c0_cmd_rw,
  input  logic                                       c0_data_valid,
  output logic                                       c0_data_ready,
  input  logic [127:0]                               c0_data_bits,
  output logic                                       c0_resp_valid,
  output logic [127:0]                               c0_resp_data,
  output logic [CTAG_W-1:0]                          c0_resp_tag,
  input  logic                                       c1_cmd_valid,
  output logic                                       c1_cmd_ready,
  input  logic [ADDR_W-1:0]                          c1_cmd_addr,
  input  logic [CTAG_W-1:0]                          c1_cmd_tag,
  input  logic                                       c1_cmd_rw,
  input  logic                                       c1_data_valid,
  output logic                                       c1_data_ready,
  input  logic [127:0]                               c1_data_bits,
  output logic                                       c1_resp_valid,
  output logic [127:0]                               c1_resp_data,
  output logic [CTAG_W-1:0]                          c1_resp_tag,
  output logic                                       m_cmd_valid,
  input  logic                                       m_cmd_ready,
  output logic [ADDR_W-1:0]                          m_cmd_addr,
  output logic [CTAG_W+mem_port_arbiter_pkg::ID_W-1:0] m_cmd_tag,
  output logic                                       m_cmd_rw,
  output logic                                       m_data_valid,
  input  logic                                       m_data_ready,
  output logic [127:0]                               m_data_bits,
  input  logic                                       m_resp_valid,
  input  logic [127:0]                               m_resp_data,
  input  logic [CTAG_W+mem_port_arbiter_pkg::ID_W-1:0] m_resp_tag,
  output logic                                       grant,
  output logic                                       busy
);
  import mem_port_arbiter_pkg::*;
  localparam int BW = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(DATA_BEATS - 1);
  state_t state, state_n;
  logic last, win, sel_valid, sel_rw, sel_dvalid, cmd_hs, data_hs, in_wdata, burst_end;
  logic [ADDR_W-1:0] sel_addr;
  logic [CTAG_W-1:0] sel_tag;
  logic [BW-1:0] beat;
  rr_arb2 u_arb (.req({c1_cmd_valid, c0_cmd_valid}), .last(last), .win(win));
  always_comb begin
    sel_valid = grant ? c1_cmd_valid : c0_cmd_valid;
    sel_rw = grant ? c1_cmd_rw : c0_cmd_rw;
    sel_dvalid = grant ? c1_data_valid : c0_data_valid;
    sel_addr = grant ? c1_cmd_addr : c0_cmd_addr;
    sel_tag = grant ? c1_cmd_tag : c0_cmd_tag;
    in_wdata = state == WDATA;
    m_cmd_valid = (state == CMD) && sel_valid && (!sel_rw || sel_dvalid);
    m_cmd_addr = sel_addr;
    m_cmd_rw = sel_rw;
    m_cmd_tag = {grant, sel_tag};
    cmd_hs = m_cmd_valid && m_cmd_ready;
    c0_cmd_ready = cmd_hs && !grant;
    c1_cmd_ready = cmd_hs && grant;
    m_data_valid = in_wdata && sel_dvalid;
    m_data_bits = grant ? c1_data_bits : c0_data_bits;
    c0_data_ready = in_wdata && !grant && m_data_ready;
    c1_data_ready = in_wdata && grant && m_data_ready;
    data_hs = m_data_valid && m_data_ready;
    burst_end = data_hs && beat == LAST_BEAT;
    busy = state != IDLE;
    state_n = state;
    case (state)
      IDLE:    state_n = (c0_cmd_valid || c1_cmd_valid) ? CMD : IDLE;
      CMD:     state_n = !sel_valid ? IDLE : !cmd_hs ? CMD : sel_rw ? WDATA : IDLE;
      WDATA:   state_n = burst_end ? IDLE : WDATA;
      default: state_n = IDLE;
    endcase
  end
  // Responses bypass the FSM entirely; the tag MSB names the owning client.
  always_comb begin
    c0_resp_valid = reset_n && m_resp_valid && !m_resp_tag[CTAG_W];
    c1_resp_valid = reset_n && m_resp_valid && m_resp_tag[CTAG_W];
    c0_resp_tag = m_resp_tag[CTAG_W-1:0];
    c1_resp_tag = m_resp_tag[CTAG_W-1:0];
    c0_resp_data = m_resp_data;
    c1_resp_data = m_resp_data;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= 1'b0;
      last <= 1'b1;
      beat <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && (c0_cmd_valid || c1_cmd_valid)) grant <= win;
      if (cmd_hs) last <= grant;
      if (cmd_hs || burst_end) beat <= '0;
      else if (data_hs) beat <= beat + 1'b1;
    end
  end
endmodule
